// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the execute-stage multiply/divide unit:
// operation codes, FSM state encoding and the default operand width.
package ex_muldiv_pkg;

  localparam int MD_WIDTH = 32;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  typedef enum logic [2:0] {
    MD_IDLE = 3'd0,
    MD_MUL  = 3'd1,
    MD_DIV_ST = 3'd2,
    MD_FIX  = 3'd3,
    MD_DONE = 3'd4
  } md_state_t;

endpackage

// File: rtl/ex_muldiv_divstep.sv
// One radix-2 restoring division step on unsigned magnitudes:
// shift {rem, quo} left, trial-subtract the divisor, keep on no borrow.
module ex_muldiv_divstep #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] i_rem,
  input  logic [WIDTH-1:0] i_quo,
  input  logic [WIDTH-1:0] i_dvs,
  output logic [WIDTH-1:0] o_rem,
  output logic [WIDTH-1:0] o_quo
);

  logic [WIDTH:0] w_shift;
  logic [WIDTH:0] w_trial;

  // rem < dvs on entry, so the shifted value fits in WIDTH+1 bits and the
  // top bit of the trial difference is exactly the borrow.
  assign w_shift = {i_rem, i_quo[WIDTH-1]};
  assign w_trial = w_shift - {1'b0, i_dvs};

  assign o_rem = w_trial[WIDTH] ? w_shift[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign o_quo = {i_quo[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule

// File: rtl/ex_muldiv.sv
// Multi-cycle multiply/divide unit: pipelined multiply, iterative restoring
// divide, {hi, lo} result with a ready pulse. Optional: MULDIV_EARLY_OUT_EN.
module ex_muldiv
  import ex_muldiv_pkg::*;
#(
  parameter int WIDTH      = MD_WIDTH,
  parameter int MUL_STAGES = 2,
  parameter int CNT_W      = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] opa_i,
  input  logic [WIDTH-1:0] opb_i,
  output logic             busy_o,
  output logic             ready_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stallreq_o,
  output logic             dbz_o
);

  md_state_t r_state, w_state_next;

  logic [CNT_W-1:0] r_cnt;
  logic             r_signed;
  logic             r_sign_a;
  logic             r_sign_b;
  logic             r_dbz;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_rem;
  logic [WIDTH-1:0] r_quo;
  logic [WIDTH-1:0] r_dvs;
  logic [WIDTH-1:0] r_hi;
  logic [WIDTH-1:0] r_lo;

  // Issue-side decode of the incoming request.
  logic             w_start;
  logic             w_is_div;
  logic             w_is_signed;
  logic             w_a_neg;
  logic             w_b_neg;
  logic [WIDTH-1:0] w_a_mag;
  logic [WIDTH-1:0] w_b_mag;
  logic             w_b_zero;
  logic             w_early;

  assign w_start     = start_i & ~flush_i;
  assign w_is_div    = op_i[1];
  assign w_is_signed = ~op_i[0];
  assign w_a_neg     = w_is_signed & opa_i[WIDTH-1];
  assign w_b_neg     = w_is_signed & opb_i[WIDTH-1];
  assign w_a_mag     = w_a_neg ? (~opa_i + 1'b1) : opa_i;
  assign w_b_mag     = w_b_neg ? (~opb_i + 1'b1) : opb_i;
  assign w_b_zero    = (opb_i == '0);

`ifdef MULDIV_EARLY_OUT_EN
  // A zero divisor never satisfies this, so it cannot mask divide-by-zero.
  assign w_early = (w_b_mag > w_a_mag);
`else
  assign w_early = 1'b0;
`endif

  // Multiplier: sign-extend both operands to 2*WIDTH so one unsigned
  // multiply yields the correct low 2*WIDTH bits for MULT and MULTU.
  logic [2*WIDTH-1:0] w_a_ext;
  logic [2*WIDTH-1:0] w_b_ext;
  logic [2*WIDTH-1:0] w_prod;
  logic [2*WIDTH-1:0] w_mul_tail;

  assign w_a_ext = {{WIDTH{r_signed & r_opa[WIDTH-1]}}, r_opa};
  assign w_b_ext = {{WIDTH{r_signed & r_opb[WIDTH-1]}}, r_opb};
  assign w_prod  = w_a_ext * w_b_ext;

  // The hi/lo result register is the last multiply stage.
  generate
    if (MUL_STAGES == 1) begin : g_mul_direct
      assign w_mul_tail = w_prod;
    end else begin : g_mul_pipe
      logic [2*WIDTH-1:0] r_pipe [MUL_STAGES-1];
      for (genvar gi = 0; gi < MUL_STAGES-1; gi++) begin : g_stage
        if (gi == 0) begin : g_first
          always_ff @(posedge clk) r_pipe[gi] <= w_prod;
        end else begin : g_next
          always_ff @(posedge clk) r_pipe[gi] <= r_pipe[gi-1];
        end
      end
      assign w_mul_tail = r_pipe[MUL_STAGES-2];
    end
  endgenerate

  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;

  ex_muldiv_divstep #(.WIDTH(WIDTH)) u_divstep (
    .i_rem (r_rem),
    .i_quo (r_quo),
    .i_dvs (r_dvs),
    .o_rem (w_step_rem),
    .o_quo (w_step_quo)
  );

  logic [WIDTH-1:0] w_fix_quo;
  logic [WIDTH-1:0] w_fix_rem;

  assign w_fix_quo = (r_signed & (r_sign_a ^ r_sign_b)) ? (~r_quo + 1'b1) : r_quo;
  assign w_fix_rem = (r_signed & r_sign_a) ? (~r_rem + 1'b1) : r_rem;

  always_ff @(posedge clk) begin
    if (rst) r_state <= MD_IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    busy_o       = (r_state != MD_IDLE);
    ready_o      = 1'b0;
    stallreq_o   = 1'b0;
    dbz_o        = 1'b0;
    case (r_state)
      MD_IDLE: begin
        stallreq_o = w_start;
        if (w_start) begin
          if (!w_is_div)              w_state_next = MD_MUL;
          else if (w_b_zero || w_early) w_state_next = MD_DONE;
          else                        w_state_next = MD_DIV_ST;
        end
      end
      MD_MUL: begin
        stallreq_o = 1'b1;
        if (r_cnt == '0) w_state_next = MD_DONE;
      end
      MD_DIV_ST: begin
        stallreq_o = 1'b1;
        if (r_cnt == '0) w_state_next = MD_FIX;
      end
      MD_FIX: begin
        stallreq_o   = 1'b1;
        w_state_next = MD_DONE;
      end
      MD_DONE: begin
        ready_o      = 1'b1;
        dbz_o        = r_dbz;
        w_state_next = MD_IDLE;
      end
      default: w_state_next = MD_IDLE;
    endcase
    if (flush_i) w_state_next = MD_IDLE;
  end

  // Result registers only load on a transition into DONE, so a flush
  // (which forces IDLE) leaves the previous hi/lo visible.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt <= '0;
      r_hi  <= '0;
      r_lo  <= '0;
      r_dbz <= 1'b0;
    end else begin
      case (r_state)
        MD_IDLE: begin
          if (w_start) begin
            r_signed <= w_is_signed;
            r_sign_a <= w_a_neg;
            r_sign_b <= w_b_neg;
            r_opa    <= opa_i;
            r_opb    <= opb_i;
            r_rem    <= '0;
            r_quo    <= w_a_mag;
            r_dvs    <= w_b_mag;
            r_dbz    <= w_is_div & w_b_zero;
            r_cnt    <= w_is_div ? CNT_W'(WIDTH-1) : CNT_W'(MUL_STAGES-1);
            if (w_state_next == MD_DONE) begin
              r_hi <= opa_i;
              r_lo <= w_b_zero ? '1 : '0;
            end
          end
        end
        MD_MUL: begin
          r_cnt <= r_cnt - 1'b1;
          if (w_state_next == MD_DONE) {r_hi, r_lo} <= w_mul_tail;
        end
        MD_DIV_ST: begin
          r_cnt <= r_cnt - 1'b1;
          r_rem <= w_step_rem;
          r_quo <= w_step_quo;
        end
        MD_FIX: begin
          if (w_state_next == MD_DONE) begin
            r_hi <= w_fix_rem;
            r_lo <= w_fix_quo;
          end
        end
        default: ;
      endcase
    end
  end

  assign hi_o = r_hi;
  assign lo_o = r_lo;

endmodule
